// File: rtl/bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// bcd_scan_decoder
//
// Registered, multiplexed successor to the combinational 4-to-10 BCD decoder.
// It holds DIGITS BCD digits and time-multiplexes them onto one shared
// active-low decimal bus. A second select bus, also active-low, shows which
// digit is currently being driven.
//
// Each digit gets a slot of PRESCALE clock cycles. Cycle 0 of every slot is
// blank, so the lamp driver never ghosts one digit into its neighbour. A new
// digit vector is double-buffered and only adopted at a frame boundary, so a
// frame is never torn.
//
// Optional feature:
//   BCD_SCAN_LZB_EN - leading-zero blanking. When this macro is defined, any
//                     digit above digit 0 that is zero, and whose higher
//                     digits are all zero, is blanked for its whole slot.
//
// Parameters:
//   DIGITS   - number of BCD digits scanned (1..16); digit 0 is the LSD
//   PRESCALE - clock cycles per digit slot (>= 2); cycle 0 is blank
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   load_valid - producer offers a new digit vector
//   load_ready - block can accept load_bcd this cycle
//   load_bcd   - digit i in bits [4i+3:4i]
//   dec_n      - active-low decimal lines; bit k low shows value k
//   dig_sel_n  - active-low select of the digit currently driven
//   invalid    - high while a digit with code 10..15 is in its drive cycles
//   frame_done - one-cycle pulse on the last cycle of slot DIGITS-1
// ---------------------------------------------------------------------------
module bcd_scan_decoder #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_bcd,
   output logic [9:0]            dec_n,
   output logic [DIGITS-1:0]     dig_sel_n,
   output logic                  invalid,
   output logic                  frame_done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] S_LAST = DW'(DIGITS - 1);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t              state;
   logic [4*DIGITS-1:0] active_q;
   logic [4*DIGITS-1:0] pending_q;
   logic [PW-1:0]       p_q;
   logic [DW-1:0]       s_q;
   logic                accept;
   logic [3:0]          cur_code;
   logic                drive_slot;

   // load_ready is the inverse of the pending-full flag. Keeping only
   // load_ready as the flop lets that output come straight from a register.
   // The pending buffer is therefore full exactly when load_ready is low.
   assign accept = load_valid & load_ready;

   // Select the code of the digit under the scan pointer. A compare loop is
   // used rather than a variable part-select, so non-power-of-two DIGITS
   // never produce an out-of-range index.
   always_comb begin
      cur_code = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s_q == DW'(i)) begin
            cur_code = active_q[4*i +: 4];
         end
      end
   end

`ifdef BCD_SCAN_LZB_EN
   logic [DIGITS-1:0] lz_mask;
   logic              cur_blank;

   // Walk from the most significant digit downward. A digit is a leading
   // zero while it and everything above it are zero. Digit 0 always shows,
   // so a value of zero still displays a single "0".
   always_comb begin : lz_calc
      logic zero_above;
      zero_above = 1'b1;
      lz_mask    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (active_q[4*i +: 4] == 4'h0);
         if (i != 0) begin
            lz_mask[i] = zero_above;
         end
      end
   end

   // Look up the blanking flag for the digit under the scan pointer.
   always_comb begin
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s_q == DW'(i)) begin
            cur_blank = lz_mask[i];
         end
      end
   end
`endif

   // A slot drives the bus on every cycle except its first one. With
   // leading-zero blanking enabled, a blanked digit also stays dark for its
   // whole slot.
   always_comb begin
      drive_slot = (state == SCAN) && (p_q != '0);
`ifdef BCD_SCAN_LZB_EN
      drive_slot = drive_slot && !cur_blank;
`endif
   end

   // Single sequential block: FSM, scan counters, double buffer and all
   // registered outputs.
   //
   // Every output is computed from the (s,p) position held this cycle, so
   // the outputs trail the counters by exactly one cycle. As a result,
   // frame_done is high during the cycle in which the counters have just
   // wrapped to slot 0, cycle 0. The pending-to-active transfer happens at
   // the end of that cycle. Slot 0 is still blank at that point, so the new
   // digits first appear on slot 0's first drive cycle and no frame mixes
   // old and new data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         active_q   <= '0;
         pending_q  <= '0;
         load_ready <= 1'b1;
         p_q        <= '0;
         s_q        <= '0;
         dec_n      <= '1;
         dig_sel_n  <= '1;
         invalid    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == SCAN) && (s_q == S_LAST) && (p_q == P_LAST);

         if (drive_slot) begin
            dig_sel_n <= ~(DIGITS'(1) << s_q);
            if (cur_code <= 4'd9) begin
               dec_n   <= ~(10'(1) << cur_code);
               invalid <= 1'b0;
            end else begin
               dec_n   <= '1;
               invalid <= 1'b1;
            end
         end else begin
            dig_sel_n <= '1;
            dec_n     <= '1;
            invalid   <= 1'b0;
         end

         case (state)
            IDLE: begin
               // The first vector bypasses the pending buffer, and scanning
               // starts next cycle at slot 0, cycle 0.
               if (accept) begin
                  active_q <= load_bcd;
                  state    <= SCAN;
                  p_q      <= '0;
                  s_q      <= '0;
               end
            end

            SCAN: begin
               if (p_q == P_LAST) begin
                  p_q <= '0;
                  s_q <= (s_q == S_LAST) ? '0 : s_q + DW'(1);
               end else begin
                  p_q <= p_q + PW'(1);
               end

               // At a frame boundary a waiting vector is promoted. A load
               // can only be accepted while the buffer is empty, so these
               // two branches never compete for pending_q.
               if (frame_done && !load_ready) begin
                  active_q   <= pending_q;
                  load_ready <= 1'b1;
               end else if (accept) begin
                  pending_q  <= load_bcd;
                  load_ready <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_decoder
//
// Scoreboard bench for bcd_scan_decoder (DIGITS=4, PRESCALE=4).
//
// The stimulus process drives the inputs and advances a behavioural display
// model by one clock. The model tracks the elapsed cycles since the scan
// started, the digits on show and a one-entry pending slot. From these it
// pushes the output expected after the edge into a queue. A separate monitor
// pops one entry on every falling edge and compares it with the DUT outputs.
//
// Sequence of stimulus:
//   1. The directed cases from the test plan.
//   2. A randomized run.
// ---------------------------------------------------------------------------
module tb_bcd_scan_decoder;

   localparam int D = 4;
   localparam int P = 4;

   typedef struct packed {
      logic [9:0]   dec;
      logic [D-1:0] sel;
      logic         inv;
      logic         fd;
      logic         rdy;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           load_valid;
   logic           load_ready;
   logic [4*D-1:0] load_bcd;
   logic [9:0]     dec_n;
   logic [D-1:0]   dig_sel_n;
   logic           invalid;
   logic           frame_done;

   exp_t exp_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   // Model state: scan position as elapsed cycles since the scan started.
   bit m_started   = 0;
   int m_k         = 0;
   int m_shown[D];
   bit m_pend_full = 0;
   int m_pend[D];

   bcd_scan_decoder #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_bcd   (load_bcd),
      .dec_n      (dec_n),
      .dig_sel_n  (dig_sel_n),
      .invalid    (invalid),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

`ifdef BCD_SCAN_LZB_EN
   // A digit above 0 is dark when it and all higher digits are zero.
   function automatic bit lzBlank(int s);
      if (s == 0) return 1'b0;
      for (int j = s; j < D; j++) begin
         if (m_shown[j] != 0) return 1'b0;
      end
      return 1'b1;
   endfunction
`endif

   // Advance the model by one clock and queue the output expected after it.
   task automatic modelStep(input bit r, input bit v, input logic [4*D-1:0] bcd);
      exp_t e;
      bit   was_started;
      bit   accepted;
      int   s;
      int   p;
      bit   blank;
      e.dec = 10'h3FF;
      e.sel = '1;
      e.inv = 1'b0;
      e.fd  = 1'b0;
      e.rdy = 1'b1;
      if (r) begin
         m_started   = 0;
         m_k         = 0;
         m_pend_full = 0;
         for (int i = 0; i < D; i++) begin
            m_shown[i] = 0;
            m_pend[i]  = 0;
         end
      end else begin
         was_started = m_started;
         if (m_started) begin
            s     = (m_k / P) % D;
            p     = m_k % P;
            blank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
            blank = lzBlank(s);
`endif
            if (p != 0 && !blank) begin
               e.sel[s] = 1'b0;
               if (m_shown[s] <= 9) e.dec[m_shown[s]] = 1'b0;
               else e.inv = 1'b1;
            end
            e.fd = ((m_k % (D*P)) == (D*P - 1));
         end
         accepted = v && !m_pend_full;
         // A waiting vector is adopted at the start of every frame after
         // the first one.
         if (m_started && m_k > 0 && (m_k % (D*P)) == 0 && m_pend_full) begin
            m_shown     = m_pend;
            m_pend_full = 0;
         end
         if (accepted) begin
            if (!was_started) begin
               for (int i = 0; i < D; i++) m_shown[i] = int'(bcd[4*i +: 4]);
               m_started = 1;
            end else begin
               for (int i = 0; i < D; i++) m_pend[i] = int'(bcd[4*i +: 4]);
               m_pend_full = 1;
            end
         end
         if (was_started) m_k++;
         else m_k = 0;
         e.rdy = !m_pend_full;
      end
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs, then let the model follow the edge.
   task automatic applyStimulus(input bit r, input bit v, input logic [4*D-1:0] bcd);
      rst        = r;
      load_valid = v;
      load_bcd   = bcd;
      @(posedge clk);
      modelStep(r, v, bcd);
      #1;
   endtask

   task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareField("dec_n",      32'(dec_n),      32'(e.dec));
      compareField("dig_sel_n",  32'(dig_sel_n),  32'(e.sel));
      compareField("invalid",    32'(invalid),    32'(e.inv));
      compareField("frame_done", 32'(frame_done), 32'(e.fd));
      compareField("load_ready", 32'(load_ready), 32'(e.rdy));
   endtask

   // Monitor: one expected entry per clock, compared away from the edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   function automatic logic [4*D-1:0] randBcd();
      logic [4*D-1:0] v;
      int             x;
      for (int i = 0; i < D; i++) begin
         x = $urandom_range(0, 9);
         if (x < 2) v[4*i +: 4] = 4'h0;
         else if (x < 4) v[4*i +: 4] = 4'($urandom_range(10, 15));
         else v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) v[4*D-1 -: 8] = 8'h00;
      return v;
   endfunction

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_bcd   = '0;

      // Reset, then idle for 20 cycles with no load.
      applyStimulus(1, 0, '0);
      applyStimulus(1, 0, '0);
      repeat (20) applyStimulus(0, 0, '0);

      // First load in IDLE, then two full frames.
      applyStimulus(0, 1, 16'h9410);
      repeat (2*D*P + 2) applyStimulus(0, 0, '0);

      // Mid-frame load, then hold a second one through the boundary.
      applyStimulus(0, 1, 16'h1234);
      repeat (3*D*P) applyStimulus(0, 1, 16'h5678);
      repeat (D*P) applyStimulus(0, 0, '0);

      // Invalid code in slot 1.
      applyStimulus(1, 0, '0);
      applyStimulus(0, 1, 16'h00A3);
      repeat (2*D*P) applyStimulus(0, 0, '0);

      // Reset at slot 2 cycle 2 while the pending buffer is full.
      applyStimulus(1, 0, '0);
      applyStimulus(0, 1, 16'h0050);
      repeat (5) applyStimulus(0, 0, '0);
      applyStimulus(0, 1, 16'h0731);
      for (int n = 0; n < 4*D*P; n++) begin
         if (m_k == 2*P + 2) break;
         applyStimulus(0, 0, '0);
      end
      applyStimulus(1, 0, '0);
      repeat (3) applyStimulus(0, 0, '0);

      // Leading-zero pattern shown for two frames.
      applyStimulus(0, 1, 16'h0050);
      repeat (2*D*P) applyStimulus(0, 0, '0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 800; n++) begin
         applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0), randBcd());
      end

      // Drain the scoreboard under a bounded wait.
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
